// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//   state_e     : FSM state encoding (idle / run / pause)
//   DP_PATTERN  : active-low decimal-point pattern, point after hexa2 (SS.cc)
//   bcd_inc     : +1 on a packed 4-digit BCD value, 9999 wraps to 0000
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } state_e;

  localparam logic [3:0] DP_PATTERN = 4'b1011;

  // Digit 0 lives in value[3:0]; a carry ripples upward only past a 9.
  function automatic logic [15:0] bcd_inc(input logic [15:0] value);
    logic [15:0] res;
    logic        carry;
    res   = value;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (res[i*4 +: 4] == 4'd9) begin
          res[i*4 +: 4] = 4'd0;
        end else begin
          res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/display bundle of the stopwatch controller.
//   btn_ss, btn_clr : raw asynchronous buttons, active-high
//   hexa3..hexa0    : BCD digits, tens of seconds down to hundredths
//   dps             : per-digit decimal points, active-low
//   running         : high while the stopwatch is counting
// slave is the controller side, master the button/display side.
interface stopwatch_ctrl_if;

  logic       btn_ss;
  logic       btn_clr;
  logic [3:0] hexa3;
  logic [3:0] hexa2;
  logic [3:0] hexa1;
  logic [3:0] hexa0;
  logic [3:0] dps;
  logic       running;

  modport master (
    output btn_ss,
    output btn_clr,
    input  hexa3,
    input  hexa2,
    input  hexa1,
    input  hexa0,
    input  dps,
    input  running
  );

  modport slave (
    input  btn_ss,
    input  btn_clr,
    output hexa3,
    output hexa2,
    output hexa1,
    output hexa0,
    output dps,
    output running
  );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, level debouncer, rising-edge pulse.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   btn_i   : raw asynchronous button level, active-high
//   press_o : one-cycle pulse when the debounced level goes 0 -> 1
// After reset the block stays disarmed until the button has been seen
// released for DB_CNT consecutive cycles, so a button held through reset
// release never turns into a press.
module btn_debounce #(
  parameter int unsigned DB_CNT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CNT - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            stable_prev_q;
  logic            armed_q, armed_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      armed_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= btn_i;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      armed_q       <= armed_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    armed_d  = armed_q;
    cnt_d    = cnt_q;
    if (!armed_q) begin
      // Both stages must read low: the synchronizer is still flushing its
      // reset value for the first cycles after release.
      if (sync1_q || sync2_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        cnt_d   = '0;
        armed_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  assign press_o = stable_q & ~stable_prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop and clear buttons drive an idle/run/pause
// FSM; a prescaler produces 0.01 s ticks that advance a 4-digit BCD count
// (00.00 .. 99.99, wrapping).
//   clk   : system clock
//   reset : asynchronous active-low reset
//   sw    : button inputs and display outputs (slave side)
// TICK_DIV is clk cycles per tick, DB_CNT the debounce length in cycles.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned DB_CNT   = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.slave  sw
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);

  logic              ss_press, clr_press;
  state_e            state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [15:0]       bcd_q, bcd_d;

  btn_debounce #(
    .DB_CNT (DB_CNT)
  ) u_db_ss (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (sw.btn_ss),
    .press_o (ss_press)
  );

  btn_debounce #(
    .DB_CNT (DB_CNT)
  ) u_db_clr (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (sw.btn_clr),
    .press_o (clr_press)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      presc_q <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (ss_press) state_d = StRun;
      end
      StRun: begin
        if (ss_press) state_d = StPause;
        // The edge that enters PAUSE still counts; PAUSE then holds presc.
        if (presc_q == PrescLast) begin
          presc_d = '0;
          bcd_d   = bcd_inc(bcd_q);
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      StPause: begin
        if (ss_press) state_d = StRun;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Clear overrides everything, including a simultaneous start/stop.
    if (clr_press) begin
      state_d = StIdle;
      presc_d = '0;
      bcd_d   = '0;
    end
  end

  assign sw.hexa3   = bcd_q[15:12];
  assign sw.hexa2   = bcd_q[11:8];
  assign sw.hexa1   = bcd_q[7:4];
  assign sw.hexa0   = bcd_q[3:0];
  assign sw.dps     = DP_PATTERN;
  assign sw.running = (state_q == StRun);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4, DB_CNT=3. Stimulus pushes the
// expected display/running value for a given cycle into a scoreboard; a
// monitor on the falling edge pops and compares when that cycle arrives.
module tb_stopwatch_ctrl;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  int         q_cyc[$];
  logic [15:0] q_bcd[$];
  logic       q_run[$];
  bit         q_chk[$];
  string      q_name[$];

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .TICK_DIV (4),
    .DB_CNT   (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic expect_at(input int c, input logic [15:0] bcd, input logic run,
                           input bit chk_bcd, input string nm);
    q_cyc.push_back(c);
    q_bcd.push_back(bcd);
    q_run.push_back(run);
    q_chk.push_back(chk_bcd);
    q_name.push_back(nm);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic [15:0] disp();
    return {sw_if.hexa3, sw_if.hexa2, sw_if.hexa1, sw_if.hexa0};
  endfunction

  // Monitor: compare every scoreboard entry whose cycle has come up.
  always @(negedge clk) begin
    int          c;
    logic [15:0] eb;
    logic        er;
    bit          ec;
    string       nm;
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      c  = q_cyc.pop_front();
      eb = q_bcd.pop_front();
      er = q_run.pop_front();
      ec = q_chk.pop_front();
      nm = q_name.pop_front();
      if (c != cyc) begin
        checks++;
        failures++;
        $display("FAIL %s got=cyc%0d exp=cyc%0d", nm, cyc, c);
      end else begin
        cmp({nm, "_run"}, {15'd0, sw_if.running}, {15'd0, er});
        if (ec) cmp({nm, "_bcd"}, disp(), eb);
        cmp({nm, "_dps"}, {12'd0, sw_if.dps}, 16'h000b);
      end
    end
  end

  initial begin
    int b;
    int c;
    int d;
    checks         = 0;
    failures       = 0;
    reset          = 1'b0;
    sw_if.btn_ss   = 1'b0;
    sw_if.btn_clr  = 1'b0;

    // Reset state.
    wait_until(2);
    expect_at(4, 16'h0000, 1'b0, 1'b1, "reset");
    wait_until(6);
    reset = 1'b1;
    wait_until(20);

    // Start: running 6 edges after first sample, one count every 4 cycles.
    b = cyc;
    sw_if.btn_ss = 1'b1;
    expect_at(b + 5,  16'h0000, 1'b0, 1'b1, "start_pre");
    expect_at(b + 6,  16'h0000, 1'b1, 1'b1, "start_edge");
    expect_at(b + 9,  16'h0000, 1'b1, 1'b1, "tick0_pre");
    expect_at(b + 10, 16'h0001, 1'b1, 1'b1, "tick1");
    expect_at(b + 14, 16'h0002, 1'b1, 1'b1, "tick2");
    expect_at(b + 18, 16'h0003, 1'b1, 1'b1, "tick3");
    wait_until(b + 10);
    sw_if.btn_ss = 1'b0;

    // Pause with prescaler at 2, then resume: tick one RUN cycle later.
    wait_until(b + 23);
    sw_if.btn_ss = 1'b1;
    expect_at(b + 28, 16'h0005, 1'b1, 1'b1, "pause_pre");
    expect_at(b + 29, 16'h0005, 1'b0, 1'b1, "pause_edge");
    expect_at(b + 40, 16'h0005, 1'b0, 1'b1, "pause_frozen");
    wait_until(b + 28);
    sw_if.btn_ss = 1'b0;
    wait_until(b + 40);
    sw_if.btn_ss = 1'b1;
    expect_at(b + 46, 16'h0005, 1'b1, 1'b1, "resume_edge");
    expect_at(b + 47, 16'h0006, 1'b1, 1'b1, "resume_tick");
    expect_at(b + 50, 16'h0006, 1'b1, 1'b1, "resume_hold");
    expect_at(b + 51, 16'h0007, 1'b1, 1'b1, "resume_tick2");
    wait_until(b + 45);
    sw_if.btn_ss = 1'b0;

    // Start/stop and clear together while running: clear wins.
    wait_until(b + 60);
    sw_if.btn_ss  = 1'b1;
    sw_if.btn_clr = 1'b1;
    expect_at(b + 65, 16'h0000, 1'b1, 1'b0, "both_pre");
    expect_at(b + 66, 16'h0000, 1'b0, 1'b1, "both_clr");
    expect_at(b + 70, 16'h0000, 1'b0, 1'b1, "both_idle");
    wait_until(b + 65);
    sw_if.btn_ss  = 1'b0;
    sw_if.btn_clr = 1'b0;

    // Two-cycle bounce: ignored.
    wait_until(b + 80);
    sw_if.btn_ss = 1'b1;
    expect_at(b + 88,  16'h0000, 1'b0, 1'b1, "bounce_a");
    expect_at(b + 100, 16'h0000, 1'b0, 1'b1, "bounce_b");
    wait_until(b + 82);
    sw_if.btn_ss = 1'b0;

    // Long run: decade carry, full wrap, then on to 12.34.
    wait_until(b + 110);
    c = cyc;
    sw_if.btn_ss = 1'b1;
    expect_at(c + 6,              16'h0000, 1'b1, 1'b1, "long_start");
    expect_at(c + 6 + 4 * 999,    16'h0999, 1'b1, 1'b1, "at_0999");
    expect_at(c + 6 + 4 * 1000,   16'h1000, 1'b1, 1'b1, "carry_1000");
    expect_at(c + 6 + 4 * 9999,   16'h9999, 1'b1, 1'b1, "at_9999");
    expect_at(c + 6 + 4 * 10000,  16'h0000, 1'b1, 1'b1, "wrap_0000");
    expect_at(c + 6 + 4 * 10001,  16'h0001, 1'b1, 1'b1, "wrap_0001");
    expect_at(c + 6 + 4 * 11234,  16'h1234, 1'b1, 1'b1, "at_1234");
    wait_until(c + 10);
    sw_if.btn_ss = 1'b0;

    // Asynchronous reset mid-run, away from any clock edge.
    wait_until(c + 6 + 4 * 11234 + 1);
    cmp("pre_reset_bcd", disp(), 16'h1234);
    #2 reset = 1'b0;
    #1;
    cmp("async_rst_bcd", disp(), 16'h0000);
    cmp("async_rst_run", {15'd0, sw_if.running}, 16'h0000);
    cmp("async_rst_dps", {12'd0, sw_if.dps}, 16'h000b);

    // Start/stop held through reset release: no start until pressed again.
    sw_if.btn_ss = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    d = cyc;
    expect_at(d + 3,  16'h0000, 1'b0, 1'b1, "held_a");
    expect_at(d + 12, 16'h0000, 1'b0, 1'b1, "held_b");
    expect_at(d + 25, 16'h0000, 1'b0, 1'b1, "held_c");
    wait_until(d + 10);
    sw_if.btn_ss = 1'b0;
    wait_until(d + 30);
    sw_if.btn_ss = 1'b1;
    expect_at(d + 35, 16'h0000, 1'b0, 1'b1, "repress_pre");
    expect_at(d + 36, 16'h0000, 1'b1, 1'b1, "repress_run");
    expect_at(d + 40, 16'h0001, 1'b1, 1'b1, "repress_tick");
    wait_until(d + 40);
    sw_if.btn_ss = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 200 && q_cyc.size() > 0; i++) @(negedge clk);
    checks++;
    if (q_cyc.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", q_cyc.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
